// File: rtl/time_set_unit.sv
// Front-panel time-setting controller: captures live BCD time, edits it per field, commits via time_ow.
// Optional inactivity timeout in the edit states is built only when TIME_SET_TIMEOUT_EN is defined.
module time_set_unit #(
    parameter int OW_CYCLES      = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_cancel,
    input  logic [3:0] cur_sec_o,
    input  logic [3:0] cur_sec_t,
    input  logic [3:0] cur_min_o,
    input  logic [3:0] cur_min_t,
    input  logic [3:0] cur_hr_o,
    input  logic [3:0] cur_hr_t,
    output logic [3:0] sec_set_o,
    output logic [3:0] sec_set_t,
    output logic [3:0] min_set_o,
    output logic [3:0] min_set_t,
    output logic [3:0] hr_set_o,
    output logic [3:0] hr_set_t,
    output logic       time_ow,
    output logic       editing,
    output logic [1:0] field
);

    typedef enum logic [2:0] {IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

    localparam int OW_W = $clog2(OW_CYCLES + 1);
    localparam logic [OW_W-1:0] OW_LAST = OW_W'(OW_CYCLES);

    state_t          state_q, state_d;
    logic [OW_W-1:0] ow_cnt_q, ow_cnt_d;
    logic            time_ow_q, time_ow_d;
    logic [3:0]      btn_prev_q, btn_prev_d;
    logic [7:0]      hr_set_q, hr_set_d;
    logic [7:0]      min_set_q, min_set_d;
    logic [7:0]      sec_set_q, sec_set_d;
    logic            press_mode, press_inc, press_dec, press_cancel;
    logic            adjust;
    logic            timeout;

    // btn_prev_q bit order: {cancel, dec, inc, mode}; resets to 1 so held buttons do not fire.
    assign press_mode   = btn_mode   & ~btn_prev_q[0];
    assign press_inc    = btn_inc    & ~btn_prev_q[1];
    assign press_dec    = btn_dec    & ~btn_prev_q[2];
    assign press_cancel = btn_cancel & ~btn_prev_q[3];
    assign adjust       = (press_inc ^ press_dec) & ~press_mode & ~press_cancel;

    // BCD step of a tens/ones pair with wrap at the field limit (23 for hours, 59 otherwise).
    function automatic logic [7:0] bcd_step(input logic [7:0] pair, input logic up, input logic is_hr);
        logic [3:0] tens, ones, max_t, max_o;
        tens  = pair[7:4];
        ones  = pair[3:0];
        max_t = is_hr ? 4'd2 : 4'd5;
        max_o = is_hr ? 4'd3 : 4'd9;
        if (up) begin
            if (tens > max_t || (tens == max_t && ones >= max_o)) bcd_step = 8'h00;
            else if (ones >= 4'd9)                                  bcd_step = {tens + 4'd1, 4'd0};
            else                                                    bcd_step = {tens, ones + 4'd1};
        end else begin
            if (tens == 4'd0 && ones == 4'd0) bcd_step = {max_t, max_o};
            else if (ones == 4'd0)            bcd_step = {tens - 4'd1, 4'd9};
            else                              bcd_step = {tens, ones - 4'd1};
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ow_cnt_q   <= '0;
            time_ow_q  <= 1'b0;
            btn_prev_q <= 4'hF;
            hr_set_q   <= 8'h00;
            min_set_q  <= 8'h00;
            sec_set_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            ow_cnt_q   <= ow_cnt_d;
            time_ow_q  <= time_ow_d;
            btn_prev_q <= btn_prev_d;
            hr_set_q   <= hr_set_d;
            min_set_q  <= min_set_d;
            sec_set_q  <= sec_set_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ow_cnt_d = ow_cnt_q;
        case (state_q)
            IDLE: begin
                if (press_mode) state_d = EDIT_HR;
            end
            EDIT_HR, EDIT_MIN, EDIT_SEC: begin
                if (press_cancel || timeout) begin
                    state_d = IDLE;
                end else if (press_mode) begin
                    if (state_q == EDIT_HR) begin
                        state_d = EDIT_MIN;
                    end else if (state_q == EDIT_MIN) begin
                        state_d = EDIT_SEC;
                    end else begin
                        state_d  = COMMIT;
                        ow_cnt_d = OW_W'(1);
                    end
                end
            end
            COMMIT: begin
                if (ow_cnt_q == OW_LAST) begin
                    state_d  = IDLE;
                    ow_cnt_d = '0;
                end else begin
                    ow_cnt_d = ow_cnt_q + OW_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // time_ow is registered from the next state so it is high exactly while in COMMIT.
    always_comb begin
        time_ow_d = (state_d == COMMIT);
        case (state_q)
            EDIT_HR:  field = 2'b01;
            EDIT_MIN: field = 2'b10;
            EDIT_SEC: field = 2'b11;
            default:  field = 2'b00;
        endcase
        editing = (field != 2'b00);
    end

    always_comb begin
        btn_prev_d = {btn_cancel, btn_dec, btn_inc, btn_mode};
        hr_set_d   = hr_set_q;
        min_set_d  = min_set_q;
        sec_set_d  = sec_set_q;
        case (state_q)
            IDLE: begin
                if (press_mode) begin
                    hr_set_d  = {cur_hr_t, cur_hr_o};
                    min_set_d = {cur_min_t, cur_min_o};
                    sec_set_d = {cur_sec_t, cur_sec_o};
                end
            end
            EDIT_HR:  if (adjust) hr_set_d  = bcd_step(hr_set_q, press_inc, 1'b1);
            EDIT_MIN: if (adjust) min_set_d = bcd_step(min_set_q, press_inc, 1'b0);
            EDIT_SEC: if (adjust) sec_set_d = bcd_step(sec_set_q, press_inc, 1'b0);
            default: ;
        endcase
    end

`ifdef TIME_SET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            press_any;

    assign press_any = press_mode | press_inc | press_dec | press_cancel;

    // Fires on the edge where the idle count would reach TIMEOUT_CYCLES; any press restarts it.
    always_comb begin
        to_cnt_d = '0;
        timeout  = 1'b0;
        if ((state_q == EDIT_HR || state_q == EDIT_MIN || state_q == EDIT_SEC) && !press_any) begin
            if (to_cnt_q == TO_LAST - TO_W'(1)) timeout  = 1'b1;
            else                                to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign hr_set_t  = hr_set_q[7:4];
    assign hr_set_o  = hr_set_q[3:0];
    assign min_set_t = min_set_q[7:4];
    assign min_set_o = min_set_q[3:0];
    assign sec_set_t = sec_set_q[7:4];
    assign sec_set_o = sec_set_q[3:0];
    assign time_ow   = time_ow_q;

endmodule

// File: tb/tb_time_set_unit.sv
// Scoreboard bench for time_set_unit: expected {digits, time_ow, editing, field} queued per step.
// Timeout scenarios follow TIME_SET_TIMEOUT_EN, matching the DUT build.
module tb_time_set_unit;

    logic        clk;
    logic        rst_n;
    logic        btn_mode, btn_inc, btn_dec, btn_cancel;
    logic [23:0] cur;
    logic [3:0]  sec_set_o, sec_set_t, min_set_o, min_set_t, hr_set_o, hr_set_t;
    logic        time_ow, editing;
    logic [1:0]  field;

    logic [27:0] exp_q[$];
    logic [27:0] obs_q[$];
    int          n_checks;
    int          n_fail;

    time_set_unit #(.OW_CYCLES(2), .TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .btn_cancel (btn_cancel),
        .cur_sec_o  (cur[3:0]),
        .cur_sec_t  (cur[7:4]),
        .cur_min_o  (cur[11:8]),
        .cur_min_t  (cur[15:12]),
        .cur_hr_o   (cur[19:16]),
        .cur_hr_t   (cur[23:20]),
        .sec_set_o  (sec_set_o),
        .sec_set_t  (sec_set_t),
        .min_set_o  (min_set_o),
        .min_set_t  (min_set_t),
        .hr_set_o   (hr_set_o),
        .hr_set_t   (hr_set_t),
        .time_ow    (time_ow),
        .editing    (editing),
        .field      (field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] observed();
        return {hr_set_t, hr_set_o, min_set_t, min_set_o, sec_set_t, sec_set_o, time_ow, editing, field};
    endfunction

    // Drive button levels for one cycle; when chk is set, queue the expected and observed post-edge values.
    task automatic apply_step(input logic m, input logic i, input logic d, input logic c,
                              input logic chk, input logic [23:0] ed, input logic eow, input logic [1:0] ef);
        @(negedge clk);
        btn_mode   = m;
        btn_inc    = i;
        btn_dec    = d;
        btn_cancel = c;
        @(posedge clk);
        #1;
        if (chk) begin
            exp_q.push_back({ed, eow, (ef != 2'b00), ef});
            obs_q.push_back(observed());
        end
    endtask

    task automatic test_reset();
        logic [27:0] e, o;
        rst_n = 1'b0;
        btn_mode = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (observed() !== 28'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold: got %h, expected %h", observed(), 28'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply_step(1, 0, 0, 0, 1, 24'h000000, 0, 2'b00);
        apply_step(0, 0, 0, 0, 1, 24'h000000, 0, 2'b00);
        for (int k = 0; exp_q.size() != 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL reset[%0d]: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_rollover_commit();
        logic [27:0] e, o;
        cur = 24'h235958;
        apply_step(1, 0, 0, 0, 1, 24'h235958, 0, 2'b01);
        apply_step(0, 0, 0, 0, 1, 24'h235958, 0, 2'b01);
        apply_step(0, 1, 0, 0, 1, 24'h005958, 0, 2'b01);
        apply_step(0, 0, 0, 0, 1, 24'h005958, 0, 2'b01);
        apply_step(1, 0, 0, 0, 1, 24'h005958, 0, 2'b10);
        apply_step(0, 0, 0, 0, 1, 24'h005958, 0, 2'b10);
        apply_step(0, 1, 0, 0, 1, 24'h000058, 0, 2'b10);
        apply_step(0, 0, 0, 0, 1, 24'h000058, 0, 2'b10);
        apply_step(1, 0, 0, 0, 1, 24'h000058, 0, 2'b11);
        apply_step(0, 0, 0, 0, 1, 24'h000058, 0, 2'b11);
        apply_step(1, 0, 0, 0, 1, 24'h000058, 1, 2'b00);
        apply_step(0, 0, 0, 0, 1, 24'h000058, 1, 2'b00);
        apply_step(0, 0, 0, 0, 1, 24'h000058, 0, 2'b00);
        apply_step(0, 0, 0, 0, 1, 24'h000058, 0, 2'b00);
        for (int k = 0; exp_q.size() != 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL rollover_commit[%0d]: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_dec_carries();
        logic [27:0] e, o;
        cur = 24'h000030;
        apply_step(1, 0, 0, 0, 1, 24'h000030, 0, 2'b01);
        apply_step(0, 0, 0, 0, 0, 24'h000030, 0, 2'b01);
        apply_step(0, 0, 1, 0, 1, 24'h230030, 0, 2'b01);
        apply_step(0, 0, 0, 0, 0, 24'h230030, 0, 2'b01);
        apply_step(1, 0, 0, 0, 1, 24'h230030, 0, 2'b10);
        apply_step(0, 0, 0, 0, 0, 24'h230030, 0, 2'b10);
        apply_step(0, 0, 1, 0, 1, 24'h235930, 0, 2'b10);
        apply_step(0, 0, 0, 0, 0, 24'h235930, 0, 2'b10);
        apply_step(0, 1, 0, 0, 1, 24'h230030, 0, 2'b10);
        apply_step(0, 0, 0, 0, 0, 24'h230030, 0, 2'b10);
        apply_step(0, 0, 0, 1, 1, 24'h230030, 0, 2'b00);
        apply_step(0, 0, 0, 0, 0, 24'h230030, 0, 2'b00);
        cur = 24'h200930;
        apply_step(1, 0, 0, 0, 1, 24'h200930, 0, 2'b01);
        apply_step(0, 0, 0, 0, 0, 24'h200930, 0, 2'b01);
        apply_step(0, 0, 1, 0, 1, 24'h190930, 0, 2'b01);
        apply_step(0, 0, 0, 0, 0, 24'h190930, 0, 2'b01);
        apply_step(1, 0, 0, 0, 1, 24'h190930, 0, 2'b10);
        apply_step(0, 0, 0, 0, 0, 24'h190930, 0, 2'b10);
        apply_step(0, 1, 0, 0, 1, 24'h191030, 0, 2'b10);
        apply_step(0, 0, 0, 0, 0, 24'h191030, 0, 2'b10);
        apply_step(0, 0, 1, 0, 1, 24'h190930, 0, 2'b10);
        apply_step(0, 0, 0, 0, 0, 24'h190930, 0, 2'b10);
        apply_step(1, 0, 0, 0, 1, 24'h190930, 0, 2'b11);
        apply_step(0, 0, 0, 0, 0, 24'h190930, 0, 2'b11);
        apply_step(0, 1, 0, 0, 1, 24'h190931, 0, 2'b11);
        apply_step(0, 0, 0, 0, 0, 24'h190931, 0, 2'b11);
        apply_step(0, 0, 0, 1, 1, 24'h190931, 0, 2'b00);
        for (int k = 0; exp_q.size() != 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL dec_carries[%0d]: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_cancel();
        logic [27:0] e, o;
        cur = 24'h081542;
        apply_step(1, 0, 0, 0, 1, 24'h081542, 0, 2'b01);
        apply_step(0, 0, 0, 0, 0, 24'h081542, 0, 2'b01);
        apply_step(0, 1, 0, 0, 1, 24'h091542, 0, 2'b01);
        apply_step(0, 0, 0, 0, 0, 24'h091542, 0, 2'b01);
        apply_step(0, 1, 0, 0, 1, 24'h101542, 0, 2'b01);
        apply_step(0, 0, 0, 0, 0, 24'h101542, 0, 2'b01);
        apply_step(1, 0, 0, 0, 1, 24'h101542, 0, 2'b10);
        apply_step(0, 0, 0, 0, 1, 24'h101542, 0, 2'b10);
        apply_step(0, 0, 0, 1, 1, 24'h101542, 0, 2'b00);
        apply_step(0, 0, 0, 0, 1, 24'h101542, 0, 2'b00);
        apply_step(0, 0, 0, 0, 1, 24'h101542, 0, 2'b00);
        for (int k = 0; exp_q.size() != 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL cancel[%0d]: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [27:0] e, o;
        cur = 24'h123430;
        apply_step(1, 0, 0, 0, 1, 24'h123430, 0, 2'b01);
        apply_step(0, 0, 0, 0, 0, 24'h123430, 0, 2'b01);
        apply_step(1, 1, 0, 0, 1, 24'h123430, 0, 2'b10);
        apply_step(0, 0, 0, 0, 0, 24'h123430, 0, 2'b10);
        apply_step(1, 0, 0, 0, 1, 24'h123430, 0, 2'b11);
        apply_step(0, 0, 0, 0, 0, 24'h123430, 0, 2'b11);
        apply_step(0, 1, 1, 0, 1, 24'h123430, 0, 2'b11);
        apply_step(0, 0, 0, 0, 0, 24'h123430, 0, 2'b11);
        apply_step(0, 1, 0, 1, 1, 24'h123430, 0, 2'b00);
        apply_step(0, 0, 0, 0, 0, 24'h123430, 0, 2'b00);
        apply_step(1, 0, 0, 0, 1, 24'h123430, 0, 2'b01);
        apply_step(0, 0, 0, 0, 0, 24'h123430, 0, 2'b01);
        apply_step(1, 0, 0, 1, 1, 24'h123430, 0, 2'b00);
        apply_step(0, 0, 0, 0, 0, 24'h123430, 0, 2'b00);
        apply_step(0, 1, 0, 0, 1, 24'h123430, 0, 2'b00);
        apply_step(0, 0, 1, 0, 1, 24'h123430, 0, 2'b00);
        apply_step(0, 0, 0, 1, 1, 24'h123430, 0, 2'b00);
        apply_step(0, 0, 0, 0, 1, 24'h123430, 0, 2'b00);
        for (int k = 0; exp_q.size() != 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL simultaneous[%0d]: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_commit_ignores_buttons();
        logic [27:0] e, o;
        cur = 24'h010203;
        apply_step(1, 0, 0, 0, 0, 24'h010203, 0, 2'b01);
        apply_step(0, 0, 0, 0, 0, 24'h010203, 0, 2'b01);
        apply_step(1, 0, 0, 0, 0, 24'h010203, 0, 2'b10);
        apply_step(0, 0, 0, 0, 0, 24'h010203, 0, 2'b10);
        apply_step(1, 0, 0, 0, 0, 24'h010203, 0, 2'b11);
        apply_step(0, 0, 0, 0, 0, 24'h010203, 0, 2'b11);
        apply_step(1, 0, 0, 0, 1, 24'h010203, 1, 2'b00);
        apply_step(1, 1, 0, 1, 1, 24'h010203, 1, 2'b00);
        apply_step(0, 0, 1, 0, 1, 24'h010203, 0, 2'b00);
        apply_step(0, 0, 0, 0, 1, 24'h010203, 0, 2'b00);
        for (int k = 0; exp_q.size() != 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL commit_ignores[%0d]: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_commit();
        logic [27:0] e, o;
        cur = 24'h111111;
        apply_step(1, 0, 0, 0, 0, 24'h111111, 0, 2'b01);
        apply_step(0, 0, 0, 0, 0, 24'h111111, 0, 2'b01);
        apply_step(1, 0, 0, 0, 0, 24'h111111, 0, 2'b10);
        apply_step(0, 0, 0, 0, 0, 24'h111111, 0, 2'b10);
        apply_step(1, 0, 0, 0, 0, 24'h111111, 0, 2'b11);
        apply_step(0, 0, 0, 0, 0, 24'h111111, 0, 2'b11);
        apply_step(1, 0, 0, 0, 1, 24'h111111, 1, 2'b00);
        @(negedge clk);
        btn_mode = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(28'h0);
        obs_q.push_back(observed());
        @(negedge clk);
        rst_n = 1'b1;
        apply_step(0, 0, 0, 0, 1, 24'h000000, 0, 2'b00);
        apply_step(0, 0, 0, 0, 1, 24'h000000, 0, 2'b00);
        for (int k = 0; exp_q.size() != 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_commit[%0d]: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [27:0] e, o;
        cur = 24'h123430;
`ifdef TIME_SET_TIMEOUT_EN
        apply_step(1, 0, 0, 0, 1, 24'h123430, 0, 2'b01);
        repeat (98) apply_step(0, 0, 0, 0, 0, 24'h123430, 0, 2'b01);
        apply_step(0, 0, 0, 0, 1, 24'h123430, 0, 2'b01);
        apply_step(0, 0, 0, 0, 1, 24'h123430, 0, 2'b00);
        apply_step(0, 0, 0, 0, 1, 24'h123430, 0, 2'b00);
        apply_step(1, 0, 0, 0, 1, 24'h123430, 0, 2'b01);
        repeat (98) apply_step(0, 0, 0, 0, 0, 24'h123430, 0, 2'b01);
        apply_step(0, 1, 0, 0, 1, 24'h133430, 0, 2'b01);
        repeat (98) apply_step(0, 0, 0, 0, 0, 24'h133430, 0, 2'b01);
        apply_step(0, 0, 0, 0, 1, 24'h133430, 0, 2'b01);
        apply_step(0, 0, 0, 0, 1, 24'h133430, 0, 2'b00);
`else
        apply_step(1, 0, 0, 0, 1, 24'h123430, 0, 2'b01);
        repeat (1000) apply_step(0, 0, 0, 0, 0, 24'h123430, 0, 2'b01);
        apply_step(0, 0, 0, 0, 1, 24'h123430, 0, 2'b01);
        apply_step(0, 0, 0, 1, 1, 24'h123430, 0, 2'b00);
`endif
        for (int k = 0; exp_q.size() != 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL timeout[%0d]: got %h, expected %h", k, o, e);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        btn_mode   = 1'b0;
        btn_inc    = 1'b0;
        btn_dec    = 1'b0;
        btn_cancel = 1'b0;
        cur        = 24'h000000;
        $display("[TB] starting time_set_unit bench");
        test_reset();
        test_rollover_commit();
        test_dec_carries();
        test_cancel();
        test_simultaneous();
        test_commit_ignores_buttons();
        test_reset_mid_commit();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
